// File: rtl/snn_params.sv
// rtl/snn_params.sv - shared SNN datapath sizes and learning constants
package snn_params;

    localparam int M       = 784;
    localparam int W       = 24;
    localparam int Q_STEP  = 8;
    localparam int Q_DECAY = 12;
    localparam int A_PLUS  = 26;
    localparam int A_MINUS = 31;
    localparam int DECAY   = 3891;
    localparam int DT_MAX  = 63;

    // Accumulator is Q.20: a Q.8 amplitude shifted up by the Q.12 decay fraction.
    localparam int ACC_W = 24;
    localparam int IP_W  = 10;
    localparam int DT_W  = 8;

endpackage

// File: rtl/stdp_sweep_ctrl_if.sv
// rtl/stdp_sweep_ctrl_if.sv - learning request and weight-change sweep bundle
interface stdp_sweep_ctrl_if;
    import snn_params::*;

    logic              learn_req;
    logic              learn_pot;
    logic [DT_W-1:0]   learn_dt;
    logic              valid_wch;
    logic              busy;
    logic              learn_done;
    logic              start_wch;
    logic              spike_hold;
    logic [IP_W-1:0]   ip_select;
    logic [W-1:0]      del_w_plus;
    logic [W-1:0]      del_w_minus;

    modport master (
        output learn_req, learn_pot, learn_dt, valid_wch,
        input  busy, learn_done, start_wch, spike_hold, ip_select, del_w_plus, del_w_minus
    );

    modport slave (
        input  learn_req, learn_pot, learn_dt, valid_wch,
        output busy, learn_done, start_wch, spike_hold, ip_select, del_w_plus, del_w_minus
    );

endinterface

// File: rtl/stdp_decay_unit.sv
// rtl/stdp_decay_unit.sv - loadable accumulator decaying by acc*FACTOR>>SH per enabled cycle
module stdp_decay_unit
    import snn_params::*;
#(
    parameter int AW     = ACC_W,
    parameter int FACTOR = DECAY,
    parameter int SH     = Q_DECAY
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [AW-1:0] load_val_i,
    output logic [AW-1:0] acc_d_o
);

    localparam int PW = AW + SH;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] decayed;

    // FACTOR < 2**SH, so the shifted product always fits back into AW bits.
    assign decayed = AW'((PW'(acc_q) * PW'(FACTOR)) >> SH);

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (en_i) begin
            acc_d = decayed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/stdp_sweep_ctrl.sv
// rtl/stdp_sweep_ctrl.sv - STDP step-size decay and 0..M-1 weight-change sweep sequencer
module stdp_sweep_ctrl #(
    parameter int M       = snn_params::M,
    parameter int A_PLUS  = snn_params::A_PLUS,
    parameter int A_MINUS = snn_params::A_MINUS,
    parameter int DECAY   = snn_params::DECAY,
    parameter int DT_MAX  = snn_params::DT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    stdp_sweep_ctrl_if.slave bus
);

    localparam int W     = snn_params::W;
    localparam int ACC_W = snn_params::ACC_W;
    localparam int SH    = snn_params::Q_DECAY;
    localparam int IP_W  = snn_params::IP_W;
    localparam int DT_W  = snn_params::DT_W;

    typedef enum logic [1:0] {S_IDLE, S_DECAY, S_SWEEP, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic [DT_W-1:0]   cnt_q, cnt_d, dt_sat;
    logic              seen_q, seen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic              hold_q, hold_d;
    logic [IP_W-1:0]   ip_q, ip_d;
    logic [W-1:0]      plus_q, plus_d;
    logic [W-1:0]      minus_q, minus_d;
    logic              dec_load, dec_en;
    logic [ACC_W-1:0]  acc_load, acc_nxt;
    logic [W-1:0]      step;
    logic              enter, finish;

    assign dt_sat   = (bus.learn_dt > DT_W'(DT_MAX)) ? DT_W'(DT_MAX) : bus.learn_dt;
    assign dec_load = (state_q == S_IDLE) && bus.learn_req;
    assign dec_en   = (state_q == S_DECAY);
    // Potentiation uses the A_PLUS amplitude, depression A_MINUS.
    assign acc_load = ACC_W'(bus.learn_pot ? A_PLUS : A_MINUS) << SH;
    assign step     = W'(acc_nxt >> SH);

    stdp_decay_unit #(
        .AW     (ACC_W),
        .FACTOR (DECAY),
        .SH     (SH)
    ) u_decay (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dec_load),
        .en_i       (dec_en),
        .load_val_i (acc_load),
        .acc_d_o    (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        start_d = 1'b0;
        hold_d  = hold_q;
        ip_d    = ip_q;
        plus_d  = plus_q;
        minus_d = minus_q;
        enter   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.learn_req) begin
                    hold_d = bus.learn_pot;
                    cnt_d  = dt_sat;
                    seen_d = 1'b0;
                    busy_d = 1'b1;
                    if (dt_sat != '0) begin
                        state_d = S_DECAY;
                    end else begin
                        enter = 1'b1;
                    end
                end
            end
            S_DECAY: begin
                cnt_d = cnt_q - DT_W'(1);
                if (cnt_q == DT_W'(1)) begin
                    enter = 1'b1;
                end
            end
            S_SWEEP: begin
                // An early acknowledge is remembered so WAIT is skipped entirely.
                if (bus.valid_wch) begin
                    seen_d = 1'b1;
                end
                if (ip_q == IP_W'(M - 1)) begin
                    ip_d = '0;
                    if (seen_q || bus.valid_wch) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    ip_d = ip_q + IP_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.valid_wch) begin
                    finish = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter) begin
            state_d = S_SWEEP;
            start_d = 1'b1;
            ip_d    = '0;
            plus_d  = hold_d ? '0 : step;
            minus_d = hold_d ? step : '0;
        end
        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
            plus_d  = '0;
            minus_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            hold_q  <= 1'b0;
            ip_q    <= '0;
            plus_q  <= '0;
            minus_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            hold_q  <= hold_d;
            ip_q    <= ip_d;
            plus_q  <= plus_d;
            minus_q <= minus_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.learn_done  = done_q;
    assign bus.start_wch   = start_q;
    assign bus.spike_hold  = hold_q;
    assign bus.ip_select   = ip_q;
    assign bus.del_w_plus  = plus_q;
    assign bus.del_w_minus = minus_q;

endmodule

// File: tb/tb_stdp_sweep_ctrl.sv
// tb/tb_stdp_sweep_ctrl.sv - directed bench for stdp_sweep_ctrl
module tb_stdp_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    stdp_sweep_ctrl_if bus ();

    stdp_sweep_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.learn_done), 0);
        chk({tag, "_start"}, 32'(bus.start_wch), 0);
        chk({tag, "_hold"},  32'(bus.spike_hold), 0);
        chk({tag, "_ip"},    32'(bus.ip_select), 0);
        chk({tag, "_plus"},  32'(bus.del_w_plus), 0);
        chk({tag, "_minus"}, 32'(bus.del_w_minus), 0);
    endtask

    // From the first sweep cycle to the first cycle after the sweep.
    task automatic run_sweep(input string tag);
        repeat (783) tick();
        chk({tag, "_ip_last"}, 32'(bus.ip_select), 783);
        tick();
        chk({tag, "_ip_wait"}, 32'(bus.ip_select), 0);
        chk({tag, "_busy_wait"}, 32'(bus.busy), 1);
    endtask

    task automatic ack(input string tag);
        bus.valid_wch = 1'b1;
        tick();
        bus.valid_wch = 1'b0;
        chk({tag, "_done"}, 32'(bus.learn_done), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_plus_clr"}, 32'(bus.del_w_plus), 0);
        chk({tag, "_minus_clr"}, 32'(bus.del_w_minus), 0);
        chk({tag, "_hold_clr"}, 32'(bus.spike_hold), 0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.learn_done), 0);
    endtask

    function automatic int ref_step(input int amp, input int d);
        longint acc;
        acc = longint'(amp) << 12;
        for (int k = 0; k < d; k++) begin
            acc = (acc * 3891) >> 12;
        end
        return int'(acc >> 12);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.learn_req = 1'b0;
        bus.learn_pot = 1'b0;
        bus.learn_dt  = 8'd0;
        bus.valid_wch = 1'b0;
        rst_n = 1'b0;
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 0);

        // 1: potentiate, dt=0
        bus.learn_req = 1'b1; bus.learn_pot = 1'b1; bus.learn_dt = 8'd0;
        tick();
        bus.learn_req = 1'b0;
        chk("t1_start", 32'(bus.start_wch), 1);
        chk("t1_ip0", 32'(bus.ip_select), 0);
        chk("t1_minus", 32'(bus.del_w_minus), 26);
        chk("t1_plus", 32'(bus.del_w_plus), 0);
        chk("t1_hold", 32'(bus.spike_hold), 1);
        chk("t1_busy", 32'(bus.busy), 1);
        for (int i = 1; i < 784; i++) begin
            tick();
            chk("t1_ip_ramp", 32'(bus.ip_select), 32'(i));
            if (i == 1) chk("t1_start_pulse", 32'(bus.start_wch), 0);
        end
        tick();
        chk("t1_wait_ip", 32'(bus.ip_select), 0);
        chk("t1_wait_busy", 32'(bus.busy), 1);
        chk("t1_wait_minus", 32'(bus.del_w_minus), 26);
        ack("t1_ack");

        // 2: depress, dt=4
        bus.learn_req = 1'b1; bus.learn_pot = 1'b0; bus.learn_dt = 8'd4;
        tick();
        bus.learn_req = 1'b0;
        chk("t2_busy", 32'(bus.busy), 1);
        chk("t2_start_c1", 32'(bus.start_wch), 0);
        chk("t2_hold", 32'(bus.spike_hold), 0);
        repeat (3) tick();
        chk("t2_start_c4", 32'(bus.start_wch), 0);
        chk("t2_ip_decay", 32'(bus.ip_select), 0);
        tick();
        chk("t2_start_c5", 32'(bus.start_wch), 1);
        chk("t2_plus", 32'(bus.del_w_plus), 25);
        chk("t2_plus_ref", 32'(bus.del_w_plus), 32'(ref_step(31, 4)));
        chk("t2_minus", 32'(bus.del_w_minus), 0);
        run_sweep("t2");
        ack("t2_ack");

        // 3: dt=200 saturates to 63
        bus.learn_req = 1'b1; bus.learn_pot = 1'b1; bus.learn_dt = 8'd200;
        tick();
        bus.learn_req = 1'b0;
        repeat (62) tick();
        chk("t3_start_c63", 32'(bus.start_wch), 0);
        chk("t3_busy_c63", 32'(bus.busy), 1);
        tick();
        chk("t3_start_c64", 32'(bus.start_wch), 1);
        chk("t3_minus", 32'(bus.del_w_minus), 32'(ref_step(26, 63)));
        chk("t3_plus", 32'(bus.del_w_plus), 0);
        run_sweep("t3");
        ack("t3_ack");

        // 4: request held high throughout, valid 10 cycles into WAIT
        bus.learn_req = 1'b1; bus.learn_pot = 1'b0; bus.learn_dt = 8'd2;
        tick();
        n_start = 0;
        if (bus.start_wch) n_start++;
        repeat (796) begin
            tick();
            if (bus.start_wch) n_start++;
        end
        chk("t4_wait_busy", 32'(bus.busy), 1);
        chk("t4_wait_ip", 32'(bus.ip_select), 0);
        chk("t4_wait_done", 32'(bus.learn_done), 0);
        chk("t4_one_start", 32'(n_start), 1);
        bus.valid_wch = 1'b1;
        tick();
        bus.valid_wch = 1'b0;
        chk("t4_done", 32'(bus.learn_done), 1);
        chk("t4_busy_idle", 32'(bus.busy), 0);
        tick();
        bus.learn_req = 1'b0;
        chk("t4_reaccept_busy", 32'(bus.busy), 1);

        // 6: the re-accepted request (pot=0, dt=2) acknowledged during SWEEP
        chk("t6_hold", 32'(bus.spike_hold), 0);
        repeat (2) tick();
        chk("t6_start", 32'(bus.start_wch), 1);
        chk("t6_plus", 32'(bus.del_w_plus), 27);
        chk("t6_ip0", 32'(bus.ip_select), 0);
        repeat (100) tick();
        chk("t6_ip100", 32'(bus.ip_select), 100);
        bus.valid_wch = 1'b1;
        tick();
        bus.valid_wch = 1'b0;
        chk("t6_no_early_done", 32'(bus.learn_done), 0);
        chk("t6_still_busy", 32'(bus.busy), 1);
        chk("t6_ip101", 32'(bus.ip_select), 101);
        repeat (682) tick();
        chk("t6_ip_last", 32'(bus.ip_select), 783);
        tick();
        chk("t6_done", 32'(bus.learn_done), 1);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_ip_idle", 32'(bus.ip_select), 0);
        tick();
        chk("t6_done_pulse", 32'(bus.learn_done), 0);
        chk("t6_stay_idle", 32'(bus.busy), 0);

        // 5: reset mid-SWEEP, then restart
        bus.learn_req = 1'b1; bus.learn_pot = 1'b0; bus.learn_dt = 8'd0;
        tick();
        bus.learn_req = 1'b0;
        chk("t5_plus", 32'(bus.del_w_plus), 31);
        repeat (300) tick();
        chk("t5_ip300", 32'(bus.ip_select), 300);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_rel_busy", 32'(bus.busy), 0);
        bus.learn_req = 1'b1; bus.learn_pot = 1'b1; bus.learn_dt = 8'd1;
        tick();
        bus.learn_req = 1'b0;
        chk("t5_re_busy", 32'(bus.busy), 1);
        chk("t5_re_start_c1", 32'(bus.start_wch), 0);
        tick();
        chk("t5_re_start", 32'(bus.start_wch), 1);
        chk("t5_re_ip0", 32'(bus.ip_select), 0);
        chk("t5_re_minus", 32'(bus.del_w_minus), 24);
        chk("t5_re_hold", 32'(bus.spike_hold), 1);
        run_sweep("t5");
        ack("t5_ack");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
